// File: rtl/synch_pkg.sv
// synch_pkg: sync FSM state encoding, comma patterns, valid ones-count bounds and a ones-count helper
package synch_pkg;
  localparam logic [1:0] LOSS_OF_SYNC  = 2'd0;
  localparam logic [1:0] COMMA_DETECT  = 2'd1;
  localparam logic [1:0] ACQUIRE_SYNC  = 2'd2;
  localparam logic [1:0] SYNC_ACQUIRED = 2'd3;
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;
  localparam logic [3:0] ONES_MIN = 4'd4;
  localparam logic [3:0] ONES_MAX = 4'd6;
  function automatic logic [3:0] ones10(input logic [9:0] w);
    return 4'($countones(w));
  endfunction
endpackage

// File: rtl/synch_lane.sv
// synch_lane: one lane sync FSM (pudi_i in; code_sync_o, rx_even_o, sudi_o, good_cgs_o, sync_loss_o, loss_cnt_o out)
module synch_lane
  import synch_pkg::*;
#(
  parameter int COMMA_ACQ  = 3,
  parameter int BAD_LIMIT  = 4,
  parameter int GOOD_LIMIT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_i,
  input  logic             sd_i,
  input  logic             sc_i,
  input  logic             lb_i,
  input  logic [9:0]       pudi_i,
  output logic             code_sync_o,
  output logic             rx_even_o,
  output logic [9:0]       sudi_o,
  output logic [2:0]       good_cgs_o,
  output logic             sync_loss_o,
  output logic [CNT_W-1:0] loss_cnt_o
);
  localparam logic [2:0] CA = 3'(COMMA_ACQ);
  localparam logic [2:0] BL = 3'(BAD_LIMIT);
  localparam logic [2:0] GL = 3'(GOOD_LIMIT);
  logic [1:0] st_q, st_d;
  logic even_q, even_d, loss_q, loss_d;
  logic [2:0] ccnt_q, ccnt_d, bcnt_q, bcnt_d, good_q, good_d;
  logic [9:0] sudi_q;
  logic [CNT_W-1:0] lcnt_q;
  logic [3:0] ones;
  logic comma, cggood;
  assign ones = ones10(pudi_i);
  assign comma = pudi_i[9:3] == COMMA_P || pudi_i[9:3] == COMMA_N;
  assign cggood = ones >= ONES_MIN && ones <= ONES_MAX && !(comma && even_q);
  always_comb begin
    st_d = st_q;
    even_d = !even_q;
    ccnt_d = ccnt_q;
    bcnt_d = bcnt_q;
    good_d = good_q;
    loss_d = 1'b0;
    if (sc_i && !lb_i) begin
      st_d = LOSS_OF_SYNC;
      loss_d = st_q == SYNC_ACQUIRED;
      bcnt_d = '0;
      good_d = '0;
    end else case (st_q)
      LOSS_OF_SYNC: if (comma && (sd_i || lb_i)) begin
        st_d = COMMA_DETECT;
        ccnt_d = 3'd1;
        even_d = 1'b1;
      end
      COMMA_DETECT: st_d = !cggood || comma ? LOSS_OF_SYNC : ccnt_q == CA ? SYNC_ACQUIRED : ACQUIRE_SYNC;
      ACQUIRE_SYNC: if (comma && !even_q) begin
        st_d = COMMA_DETECT;
        ccnt_d = ccnt_q + 3'd1;
        even_d = 1'b1;
      end else if (!cggood) st_d = LOSS_OF_SYNC;
      default: if (!cggood) begin
        bcnt_d = bcnt_q + 3'd1;
        good_d = '0;
        if (bcnt_d == BL) begin
          st_d = LOSS_OF_SYNC;
          loss_d = 1'b1;
          bcnt_d = '0;
        end
      end else if (bcnt_q != '0) begin
        good_d = good_q + 3'd1;
        if (good_d == GL) begin
          bcnt_d = bcnt_q - 3'd1;
          good_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || pwr_i) begin
      st_q <= LOSS_OF_SYNC;
      even_q <= 1'b0;
      ccnt_q <= '0;
      bcnt_q <= '0;
      good_q <= '0;
      loss_q <= 1'b0;
      sudi_q <= '0;
    end else begin
      st_q <= st_d;
      even_q <= even_d;
      ccnt_q <= ccnt_d;
      bcnt_q <= bcnt_d;
      good_q <= good_d;
      loss_q <= loss_d;
      sudi_q <= pudi_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) lcnt_q <= '0;
    else if (!pwr_i && loss_d && !(&lcnt_q)) lcnt_q <= lcnt_q + 1'b1;
  end
  assign code_sync_o = st_q == SYNC_ACQUIRED;
  assign rx_even_o = even_q;
  assign sudi_o = sudi_q;
  assign good_cgs_o = good_q;
  assign sync_loss_o = loss_q;
  assign loss_cnt_o = lcnt_q;
endmodule

// File: rtl/synch_multilane.sv
// synch_multilane: LANES independent cl.36 sync lanes (PUDI in; CODE_SYNC, RX_EVEN, SUDI, GOOD_CGS, SYNC_LOSS, LOSS_CNT, ALL_SYNC out)
module synch_multilane
  import synch_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int COMMA_ACQ  = 3,
  parameter int BAD_LIMIT  = 4,
  parameter int GOOD_LIMIT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   POWER,
  input  logic [LANES-1:0]       SIGNAL_DETECT,
  input  logic [LANES-1:0]       SIGNAL_CHANGE,
  input  logic [10*LANES-1:0]    PUDI,
  input  logic                   MR_LOOPBACK,
  output logic [LANES-1:0]       CODE_SYNC,
  output logic [LANES-1:0]       RX_EVEN,
  output logic [10*LANES-1:0]    SUDI,
  output logic [3*LANES-1:0]     GOOD_CGS,
  output logic                   ALL_SYNC,
  output logic [LANES-1:0]       SYNC_LOSS,
  output logic [CNT_W*LANES-1:0] LOSS_CNT
);
  logic all_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    synch_lane #(
      .COMMA_ACQ(COMMA_ACQ),
      .BAD_LIMIT(BAD_LIMIT),
      .GOOD_LIMIT(GOOD_LIMIT),
      .CNT_W(CNT_W)
    ) u_lane (
      .clk(CLK),
      .rst(RESET),
      .pwr_i(POWER),
      .sd_i(SIGNAL_DETECT[i]),
      .sc_i(SIGNAL_CHANGE[i]),
      .lb_i(MR_LOOPBACK),
      .pudi_i(PUDI[10*i+:10]),
      .code_sync_o(CODE_SYNC[i]),
      .rx_even_o(RX_EVEN[i]),
      .sudi_o(SUDI[10*i+:10]),
      .good_cgs_o(GOOD_CGS[3*i+:3]),
      .sync_loss_o(SYNC_LOSS[i]),
      .loss_cnt_o(LOSS_CNT[CNT_W*i+:CNT_W])
    );
  end
  always_ff @(posedge CLK) all_q <= RESET || POWER ? 1'b0 : &CODE_SYNC;
  assign ALL_SYNC = all_q;
endmodule

// File: tb/tb_synch_multilane.sv
// tb_synch_multilane: randomized scoreboard bench against a behavioural lane model
module tb_synch_multilane;
  localparam int L = 4;
  localparam int CACQ = 3;
  localparam int BLIM = 4;
  localparam int GLIM = 4;
  localparam logic [9:0] K = 10'b0011111010;
  localparam logic [9:0] D = 10'b1001000101;
  typedef enum int {HUNT, SAW_COMMA, WAIT_COMMA, LOCKED} mph_t;
  typedef struct {
    logic [3:0] cs, ev, sl;
    logic [39:0] sudi;
    logic [11:0] gc;
    logic all;
    logic [31:0] lc;
    logic [7:0] lc2;
    int cyc;
  } exp_t;
  logic CLK = 1'b0, RESET = 1'b1, POWER = 1'b0, MR_LOOPBACK = 1'b0;
  logic [3:0] SIGNAL_DETECT = '0, SIGNAL_CHANGE = '0;
  logic [39:0] PUDI = '0;
  logic [3:0] CODE_SYNC, RX_EVEN, SYNC_LOSS, cs2, ev2, sl2;
  logic [39:0] SUDI, sudi2;
  logic [11:0] GOOD_CGS, gc2;
  logic ALL_SYNC, all2;
  logic [31:0] LOSS_CNT;
  logic [7:0] lc2;
  synch_multilane #(.LANES(L), .COMMA_ACQ(CACQ), .BAD_LIMIT(BLIM), .GOOD_LIMIT(GLIM), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .POWER(POWER), .SIGNAL_DETECT(SIGNAL_DETECT), .SIGNAL_CHANGE(SIGNAL_CHANGE),
    .PUDI(PUDI), .MR_LOOPBACK(MR_LOOPBACK), .CODE_SYNC(CODE_SYNC), .RX_EVEN(RX_EVEN), .SUDI(SUDI),
    .GOOD_CGS(GOOD_CGS), .ALL_SYNC(ALL_SYNC), .SYNC_LOSS(SYNC_LOSS), .LOSS_CNT(LOSS_CNT));
  synch_multilane #(.LANES(L), .COMMA_ACQ(CACQ), .BAD_LIMIT(BLIM), .GOOD_LIMIT(GLIM), .CNT_W(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .POWER(POWER), .SIGNAL_DETECT(SIGNAL_DETECT), .SIGNAL_CHANGE(SIGNAL_CHANGE),
    .PUDI(PUDI), .MR_LOOPBACK(MR_LOOPBACK), .CODE_SYNC(cs2), .RX_EVEN(ev2), .SUDI(sudi2),
    .GOOD_CGS(gc2), .ALL_SYNC(all2), .SYNC_LOSS(sl2), .LOSS_CNT(lc2));
  always #5 CLK = ~CLK;
  mph_t ph[L];
  bit ev[L], pulse[L], tog[L];
  int commas[L], bad[L], run[L], l8[L], l2[L];
  logic [9:0] sud[L];
  bit all_m;
  int cyc = 0, compared = 0, mismatched = 0;
  exp_t q[$];
  task automatic model_step(input bit r, input bit p, input logic [3:0] sd, input logic [3:0] sc, input bit lb, input logic [39:0] pudi);
    bit prev_all;
    exp_t e;
    prev_all = 1'b1;
    for (int i = 0; i < L; i++) prev_all &= ph[i] == LOCKED;
    all_m = (r || p) ? 1'b0 : prev_all;
    for (int i = 0; i < L; i++) begin
      logic [9:0] w;
      bit is_comma, ok, nev;
      int n;
      w = pudi[10*i+:10];
      if (r || p) begin
        ph[i] = HUNT; ev[i] = 0; commas[i] = 0; bad[i] = 0; run[i] = 0; pulse[i] = 0; sud[i] = '0;
        if (r) begin l8[i] = 0; l2[i] = 0; end
      end else begin
        sud[i] = w;
        pulse[i] = 0;
        is_comma = w[9:3] == 7'b0011111 || w[9:3] == 7'b1100000;
        n = $countones(w);
        nev = !ev[i];
        ok = n >= 4 && n <= 6 && !(is_comma && !nev);
        if (sc[i] && !lb) begin
          pulse[i] = ph[i] == LOCKED;
          ph[i] = HUNT; bad[i] = 0; run[i] = 0;
        end else case (ph[i])
          HUNT: if (is_comma && (sd[i] || lb)) begin ph[i] = SAW_COMMA; commas[i] = 1; nev = 1; end
          SAW_COMMA: ph[i] = (ok && !is_comma) ? (commas[i] == CACQ ? LOCKED : WAIT_COMMA) : HUNT;
          WAIT_COMMA: if (is_comma && nev) begin ph[i] = SAW_COMMA; commas[i]++; nev = 1; end
                      else if (!ok) ph[i] = HUNT;
          LOCKED: if (!ok) begin
                    bad[i]++; run[i] = 0;
                    if (bad[i] == BLIM) begin ph[i] = HUNT; bad[i] = 0; pulse[i] = 1; end
                  end else if (bad[i] > 0) begin
                    run[i]++;
                    if (run[i] == GLIM) begin bad[i]--; run[i] = 0; end
                  end
        endcase
        ev[i] = nev;
        if (pulse[i]) begin
          if (l8[i] < 255) l8[i]++;
          if (l2[i] < 3) l2[i]++;
        end
      end
      e.cs[i] = ph[i] == LOCKED;
      e.ev[i] = ev[i];
      e.sl[i] = pulse[i];
      e.sudi[10*i+:10] = sud[i];
      e.gc[3*i+:3] = 3'(run[i]);
      e.lc[8*i+:8] = 8'(l8[i]);
      e.lc2[2*i+:2] = 2'(l2[i]);
    end
    e.all = all_m;
    e.cyc = cyc;
    q.push_back(e);
  endtask
  task automatic apply(input bit r, input bit p, input logic [3:0] sd, input logic [3:0] sc, input bit lb, input logic [39:0] w);
    @(negedge CLK);
    RESET = r; POWER = p; SIGNAL_DETECT = sd; SIGNAL_CHANGE = sc; MR_LOOPBACK = lb; PUDI = w;
    model_step(r, p, sd, sc, lb, w);
    for (int i = 0; i < L; i++) tog[i] = !tog[i];
    cyc++;
  endtask
  function automatic logic [39:0] stream(input logic [3:0] badm, input logic [3:0] kinj);
    logic [39:0] s;
    for (int i = 0; i < L; i++) s[10*i+:10] = badm[i] ? 10'h000 : (kinj[i] || tog[i]) ? K : D;
    return s;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req, input int c);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h, required %h", nm, c, act, req);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("CODE_SYNC", 64'(CODE_SYNC), 64'(e.cs), e.cyc);
        chk("RX_EVEN", 64'(RX_EVEN), 64'(e.ev), e.cyc);
        chk("SUDI", 64'(SUDI), 64'(e.sudi), e.cyc);
        chk("GOOD_CGS", 64'(GOOD_CGS), 64'(e.gc), e.cyc);
        chk("ALL_SYNC", 64'(ALL_SYNC), 64'(e.all), e.cyc);
        chk("SYNC_LOSS", 64'(SYNC_LOSS), 64'(e.sl), e.cyc);
        chk("LOSS_CNT", 64'(LOSS_CNT), 64'(e.lc), e.cyc);
        chk("LOSS_CNT_W2", 64'(lc2), 64'(e.lc2), e.cyc);
      end
    end
  end
  initial begin
    bit lb;
    logic [39:0] w;
    logic [3:0] sd, sc;
    for (int i = 0; i < L; i++) begin tog[i] = 0; l8[i] = 0; l2[i] = 0; end
    repeat (3) apply(1, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    repeat (30) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    apply(0, 0, 4'hF, 4'h0, 0, stream(4'h1, 4'h0));
    repeat (4) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 4'hF, 4'h0, 0, stream(4'h1, 4'h0));
      apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    end
    repeat (20) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 4'hF, 4'h0, 0, stream(4'h2, 4'h0));
      apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    end
    repeat (30) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    if (tog[0]) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h1));
    repeat (20) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    apply(0, 0, 4'hF, 4'h4, 0, stream(4'h0, 4'h0));
    repeat (3) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'hF));
    repeat (30) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    apply(0, 0, 4'h0, 4'h8, 0, stream(4'h0, 4'h0));
    repeat (5) apply(0, 0, 4'h0, 4'h0, 0, stream(4'h0, 4'h0));
    apply(0, 0, 4'h0, 4'h1, 1, stream(4'h0, 4'h0));
    repeat (30) apply(0, 0, 4'h0, 4'h0, 1, stream(4'h0, 4'h0));
    lb = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < L; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        w[10*i+:10] = r < 3 ? 10'h000 : r < 6 ? 10'($urandom) : r < 8 ? K : (tog[i] ? K : D);
        sc[i] = $urandom_range(0, 99) < 1;
        sd[i] = $urandom_range(0, 99) < 96;
      end
      if ($urandom_range(0, 199) == 0) lb = !lb;
      apply($urandom_range(0, 999) == 0, $urandom_range(0, 499) == 0, sd, sc, lb, w);
    end
    repeat (20) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    repeat (2) apply(0, 1, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    repeat (20) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    repeat (2) apply(1, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    repeat (20) apply(0, 0, 4'hF, 4'h0, 0, stream(4'h0, 4'h0));
    repeat (3) @(posedge CLK);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/synch_multilane.md
Name: synch_multilane

Overview:
- Parametrised, multi-lane successor of the single-lane 1000BASE-X PCS receive synchronization block (IEEE 802.3 cl.36 sync FSM).
- Each of LANES lanes runs an independent sync FSM with configurable acquire and loss thresholds.
- Adds aggregate all-lane lock, a per-lane loss-of-sync pulse and a per-lane saturating loss counter.
- Sits between the per-lane deserializers (PUDI) and the PCS receive state machines (SUDI).

Parameters:
- LANES, 4, number of independent lanes (1..8).
- COMMA_ACQ, 3, number of even-aligned comma+good pairs needed to declare sync (2..7).
- BAD_LIMIT, 4, invalid code-group count in sync that forces LOSS_OF_SYNC (2..7).
- GOOD_LIMIT, 4, consecutive good code-groups that forgive one bad (2..7).
- CNT_W, 8, loss counter width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset; reset is synchronous and active-high.
- POWER  in  1  power_on, treated as a synchronous reset of all FSMs; counters are not cleared.
- SIGNAL_DETECT  in  LANES  per-lane signal present.
- SIGNAL_CHANGE  in  LANES  per-lane signal_detect changed pulse.
- PUDI  in  10*LANES  lane i code-group at [10i+9:10i]; bit 9 is the first bit received.
- MR_LOOPBACK  in  1  loopback; overrides SIGNAL_DETECT and ignores SIGNAL_CHANGE.
- CODE_SYNC  out  LANES  per-lane sync status.
- RX_EVEN  out  LANES  per-lane even/odd code-group indication.
- SUDI  out  10*LANES  PUDI registered one cycle.
- GOOD_CGS  out  3*LANES  per-lane good code-group counter.
- ALL_SYNC  out  1  AND of CODE_SYNC, registered.
- SYNC_LOSS  out  LANES  one-cycle pulse on SYNC_ACQUIRED to LOSS_OF_SYNC.
- LOSS_CNT  out  CNT_W*LANES  saturating count of SYNC_LOSS pulses.

Behaviour:
- Reset (RESET): all FSMs go to LOSS_OF_SYNC. Outputs reset as follows: CODE_SYNC=0, RX_EVEN=0, SUDI=0, GOOD_CGS=0, ALL_SYNC=0, SYNC_LOSS=0, LOSS_CNT=0.
- POWER=1: same as RESET except LOSS_CNT holds.
- Classification, per lane, from the current PUDI:
  - comma = PUDI[9:3] is 0011111 or 1100000.
  - invalid = ones-count not in {4,5,6}.
  - cggood = !invalid and !(comma and new parity odd).
  - cgbad = !cggood.
- Parity: RX_EVEN toggles every cycle except on entry to COMMA_DETECT, which forces RX_EVEN=1. "New parity even" means the next value of RX_EVEN is 1.
- Outputs are registered: the FSM state, RX_EVEN and SUDI all reflect the PUDI of the previous cycle.
- Priority, highest first: RESET/POWER; then SIGNAL_CHANGE[i] & !MR_LOOPBACK, which forces LOSS_OF_SYNC (a SYNC_LOSS pulse fires if the lane was in sync); then the normal transitions.
- FSM transitions:
  - LOSS_OF_SYNC (CODE_SYNC=0): comma & (SIGNAL_DETECT | MR_LOOPBACK) goes to COMMA_DETECT with ccnt=1; otherwise stay.
  - COMMA_DETECT: cggood & !comma goes to SYNC_ACQUIRED if ccnt==COMMA_ACQ, else to ACQUIRE_SYNC. Anything else goes to LOSS_OF_SYNC.
  - ACQUIRE_SYNC: comma with new parity even goes to COMMA_DETECT with ccnt+1. cgbad goes to LOSS_OF_SYNC. Otherwise stay.
  - SYNC_ACQUIRED (CODE_SYNC=1), tracking bad counter bcnt and GOOD_CGS:
    - cgbad: bcnt+1 and GOOD_CGS=0. If bcnt reaches BAD_LIMIT, go to LOSS_OF_SYNC and pulse SYNC_LOSS.
    - cggood with bcnt>0: GOOD_CGS+1. On reaching GOOD_LIMIT, bcnt-1 and GOOD_CGS=0.
    - cggood with bcnt==0: GOOD_CGS holds 0.
- CODE_SYNC rises the cycle after the final COMMA_DETECT good code-group.
- LOSS_CNT increments on a SYNC_LOSS pulse and saturates at all-ones.
- ALL_SYNC is registered one cycle after CODE_SYNC.
- Lanes are fully independent; there is no cross-lane deskew.

Decomposition:
- Package synch_pkg holds:
  - the state encoding: LOSS_OF_SYNC, COMMA_DETECT, ACQUIRE_SYNC, SYNC_ACQUIRED;
  - the comma patterns COMMA_P = 7'b0011111 and COMMA_N = 7'b1100000;
  - the valid-ones bounds.
- Sub-module synch_lane is one lane's FSM, SUDI register, counters and loss counter. The top-level generates LANES instances plus the ALL_SYNC register.

Test Plan:
- Reset to sync: after reset, lane0 receives K28.5 (0011111010) and D16.2 (1001000101), alternating, with SIGNAL_DETECT=1. CODE_SYNC[0] rises 6 cycles after the first comma sample. LOSS_CNT=0 throughout.
- Loss on bad: in sync, inject 4 spaced invalid words (0000000000) with fewer than 4 good words between them. CODE_SYNC drops, SYNC_LOSS pulses once and LOSS_CNT=1.
- Forgiveness: one invalid word followed by 4 good words returns bcnt to 0. GOOD_CGS counts 1,2,3 and then 0. A further 3 bad words do not lose sync.
- Odd comma: in sync, a comma at odd parity counts as cgbad. During ACQUIRE_SYNC it forces LOSS_OF_SYNC.
- Signal handling: a SIGNAL_CHANGE pulse forces LOSS_OF_SYNC on that lane only, and ALL_SYNC drops one cycle later. With MR_LOOPBACK=1 the same pulse is ignored, and sync is acquired with SIGNAL_DETECT=0.
- Saturation: with CNT_W=2, cause 5 losses. LOSS_CNT stops at 3. POWER=1 keeps it at 3, while RESET=1 clears it.
